// File: rtl/vec_seq_pkg.sv
// Shared types and helpers for the vector sequencer.
// Holds the FSM state enum, default sizes and the tail-mask helper.
package vec_seq_pkg;

  localparam int LANES_D     = 4;
  localparam int MAX_ELEMS_D = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vseq_state_t;

  // Lane mask of the final group: all ones unless len leaves a remainder.
  function automatic logic [31:0] last_mask(
    input int unsigned len,
    input int unsigned lanes
  );
    int unsigned r;
    r = len % lanes;
    if (r == 0) return '1;
    return (32'd1 << r) - 32'd1;
  endfunction

endpackage

// File: rtl/vec_seq_ctrl_if.sv
// Handshake bundle between the Execute stage and the vector sequencer.
// master: stage side drives start/is_mem/vlen/mem_ready/flush; slave: sequencer.
interface vec_seq_ctrl_if #(
  parameter int LANES     = 4,
  parameter int MAX_ELEMS = 32
);
  localparam int LW = $clog2(MAX_ELEMS + 1);
  localparam int GW = $clog2(MAX_ELEMS / LANES);

  logic             start_i;
  logic             is_mem_i;
  logic [LW-1:0]    vlen_i;
  logic             mem_ready_i;
  logic             flush_i;
  logic             stall_o;
  logic [GW-1:0]    grp_o;
  logic [LANES-1:0] lane_en_o;
  logic             grp_we_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, is_mem_i, vlen_i, mem_ready_i, flush_i,
    input  stall_o, grp_o, lane_en_o, grp_we_o, busy_o, done_o
  );

  modport slave (
    input  start_i, is_mem_i, vlen_i, mem_ready_i, flush_i,
    output stall_o, grp_o, lane_en_o, grp_we_o, busy_o, done_o
  );
endinterface

// File: rtl/vseq_lane_mask.sv
// Per-lane enable for the current group plus last-group detect.
// Ports: run_i, cnt_i (group counter), ngrp_i (G), rem_i (r); lane_en_o, last_o.
module vseq_lane_mask
  import vec_seq_pkg::*;
#(
  parameter int LANES = LANES_D,
  parameter int CW    = 3,
  parameter int LW    = 6
) (
  input  logic             run_i,
  input  logic [CW-1:0]    cnt_i,
  input  logic [LW-1:0]    ngrp_i,
  input  logic [LW-1:0]    rem_i,
  output logic [LANES-1:0] lane_en_o,
  output logic             last_o
);

  logic [31:0] tail;

  assign last_o = (LW'(cnt_i) == ngrp_i - LW'(1));
  assign tail   = last_mask(32'(rem_i), LANES);

  generate
    if (LANES < 32) begin : g_unused
      logic unused_tail;
      assign unused_tail = ^tail[31:LANES];
    end
  endgenerate

  always_comb begin
    lane_en_o = '0;
    if (run_i) lane_en_o = last_o ? tail[LANES-1:0] : '1;
  end

endmodule

// File: rtl/vec_seq_ctrl.sv
// Execute-stage vector sequencer: steps a vector op through lane groups.
// Ports: clk, rst_n, bus (vec_seq_ctrl_if.slave). Option: VSEQ_MEMWAIT_EN.
module vec_seq_ctrl
  import vec_seq_pkg::*;
#(
  parameter int LANES     = LANES_D,
  parameter int MAX_ELEMS = MAX_ELEMS_D
) (
  input logic           clk,
  input logic           rst_n,
  vec_seq_ctrl_if.slave bus
);

  localparam int LW = $clog2(MAX_ELEMS + 1);
  localparam int GW = $clog2(MAX_ELEMS / LANES);
  localparam int LG = $clog2(LANES);

  vseq_state_t   state_q, state_d;
  logic [GW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;

  logic [LW-1:0] vlen_c;
  logic [LW:0]   ngrp_w;
  logic [LW-1:0] ngrp;
  logic [LW-1:0] rem;
  logic          last;
  logic          run;
  logic          adv;
  logic          stall, we, done;
  logic [GW-1:0] grp;

  assign vlen_c = (bus.vlen_i > LW'(MAX_ELEMS)) ? LW'(MAX_ELEMS)
                                                 : bus.vlen_i;
  assign ngrp_w = (LW+1)'(len_q) + (LW+1)'(LANES - 1);
  assign ngrp   = LW'(ngrp_w >> LG);
  assign rem    = len_q & LW'(LANES - 1);
  assign run    = (state_q == RUN);

`ifdef VSEQ_MEMWAIT_EN
  assign adv = !bus.is_mem_i || bus.mem_ready_i;
`else
  logic unused_mem;
  assign unused_mem = bus.is_mem_i ^ bus.mem_ready_i;
  assign adv = 1'b1;
`endif

  vseq_lane_mask #(
    .LANES (LANES),
    .CW    (GW),
    .LW    (LW)
  ) u_mask (
    .run_i     (run),
    .cnt_i     (cnt_q),
    .ngrp_i    (ngrp),
    .rem_i     (rem),
    .lane_en_o (bus.lane_en_o),
    .last_o    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    stall   = 1'b0;
    we      = 1'b0;
    done    = 1'b0;
    grp     = '0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          len_d   = vlen_c;
          cnt_d   = '0;
          stall   = 1'b1;
          state_d = (vlen_c == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        grp   = cnt_q;
        if (adv) begin
          we = 1'b1;
          if (last) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + GW'(1);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a start in the same cycle.
    if (bus.flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      len_d   = len_q;
      stall   = 1'b0;
      we      = 1'b0;
      done    = 1'b0;
    end
  end

  assign bus.stall_o  = stall;
  assign bus.grp_we_o = we;
  assign bus.done_o   = done;
  assign bus.grp_o    = grp;
  assign bus.busy_o   = run;

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// Directed bench for vec_seq_ctrl (LANES=4, MAX_ELEMS=32).
// Expected values per cycle are hand-computed from the sequencer's behaviour.
module tb_vec_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vec_seq_ctrl_if #(.LANES(4), .MAX_ELEMS(32)) bus ();

  vec_seq_ctrl #(.LANES(4), .MAX_ELEMS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic drv(input bit st, input bit mem, input int vl,
                     input bit rdy, input bit fl);
    bus.start_i     = st;
    bus.is_mem_i    = mem;
    bus.vlen_i      = 6'(vl);
    bus.mem_ready_i = rdy;
    bus.flush_i     = fl;
  endtask

  // Check all outputs at the falling edge, then move past the next rise.
  task automatic cyc(input string tag, input int st, input int g,
                     input int ln, input int we, input int by,
                     input int dn);
    @(negedge clk);
    chk({tag, ".stall"}, int'(bus.stall_o), st);
    chk({tag, ".grp"},   int'(bus.grp_o), g);
    chk({tag, ".lane"},  int'(bus.lane_en_o), ln);
    chk({tag, ".we"},    int'(bus.grp_we_o), we);
    chk({tag, ".busy"},  int'(bus.busy_o), by);
    chk({tag, ".done"},  int'(bus.done_o), dn);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0);
    #2;
    cyc("rst", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Tail mask: 10 elements -> groups 1111,1111,0011
    drv(1, 0, 10, 0, 0);
    cyc("tail0", 1, 0, 0, 0, 0, 0);
    cyc("tail1", 1, 0, 15, 1, 1, 0);
    cyc("tail2", 1, 1, 15, 1, 1, 0);
    cyc("tail3", 1, 2, 3, 1, 1, 0);
    cyc("tail4", 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0);
    cyc("tail5", 0, 0, 0, 0, 0, 0);

    // Zero length
    drv(1, 0, 0, 0, 0);
    cyc("zero0", 1, 0, 0, 0, 0, 0);
    cyc("zero1", 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0);
    cyc("zero2", 0, 0, 0, 0, 0, 0);

    // Clamp: 40 -> 32 elements, 8 full groups; is_mem with ready low
    // must not matter unless memory waits are built in.
`ifdef VSEQ_MEMWAIT_EN
    drv(1, 0, 40, 0, 0);
`else
    drv(1, 1, 40, 0, 0);
`endif
    cyc("clmp0", 1, 0, 0, 0, 0, 0);
    for (int g = 0; g < 8; g++)
      cyc($sformatf("clmp_g%0d", g), 1, g, 15, 1, 1, 0);
    cyc("clmp9", 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0);
    cyc("clmp10", 0, 0, 0, 0, 0, 0);

`ifdef VSEQ_MEMWAIT_EN
    // Memory wait: ready low for 3 cycles on group 1
    drv(1, 1, 8, 1, 0);
    cyc("mw0", 1, 0, 0, 0, 0, 0);
    cyc("mw1", 1, 0, 15, 1, 1, 0);
    drv(1, 1, 8, 0, 0);
    cyc("mw2", 1, 1, 15, 0, 1, 0);
    cyc("mw3", 1, 1, 15, 0, 1, 0);
    cyc("mw4", 1, 1, 15, 0, 1, 0);
    drv(1, 1, 8, 1, 0);
    cyc("mw5", 1, 1, 15, 1, 1, 0);
    cyc("mw6", 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0);
    cyc("mw7", 0, 0, 0, 0, 0, 0);
`endif

    // Mid-run flush on group 1 of a 4-group op, restart two cycles later
    drv(1, 0, 16, 0, 0);
    cyc("fl0", 1, 0, 0, 0, 0, 0);
    cyc("fl1", 1, 0, 15, 1, 1, 0);
    drv(1, 0, 16, 0, 1);
    cyc("fl2", 0, 1, 15, 0, 1, 0);
    drv(0, 0, 0, 0, 0);
    cyc("fl3", 0, 0, 0, 0, 0, 0);
    drv(1, 0, 8, 0, 0);
    cyc("fl4", 1, 0, 0, 0, 0, 0);
    cyc("fl5", 1, 0, 15, 1, 1, 0);
    cyc("fl6", 1, 1, 15, 1, 1, 0);
    cyc("fl7", 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0);
    cyc("fl8", 0, 0, 0, 0, 0, 0);

    // Back-to-back 8-element ops with start held high throughout
    drv(1, 0, 8, 0, 0);
    cyc("bb0", 1, 0, 0, 0, 0, 0);
    cyc("bb1", 1, 0, 15, 1, 1, 0);
    cyc("bb2", 1, 1, 15, 1, 1, 0);
    cyc("bb3", 0, 0, 0, 0, 0, 1);
    cyc("bb4", 1, 0, 0, 0, 0, 0);
    cyc("bb5", 1, 0, 15, 1, 1, 0);
    cyc("bb6", 1, 1, 15, 1, 1, 0);
    cyc("bb7", 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0);
    cyc("bb8", 0, 0, 0, 0, 0, 0);

    // Reset mid-run: outputs clear at once, no done afterwards
    drv(1, 0, 16, 0, 0);
    cyc("rr0", 1, 0, 0, 0, 0, 0);
    cyc("rr1", 1, 0, 15, 1, 1, 0);
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0);
    #1;
    chk("rr_async.busy", int'(bus.busy_o), 0);
    chk("rr_async.lane", int'(bus.lane_en_o), 0);
    chk("rr_async.stall", int'(bus.stall_o), 0);
    cyc("rr2", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc("rr3", 0, 0, 0, 0, 0, 0);
    cyc("rr4", 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
